// File: rtl/pc_trace_unit_pkg.sv
// Shared types and constants for the PC trace unit: entry layout,
// default fetch-state encoding and status flag bit positions.
package trace_pkg;

   localparam int TRACE_XLEN  = 32;
   localparam int TRACE_SEQ_W = 16;

   localparam logic [4:0] FETCH_STATE_DEF = 5'b00001;

   localparam int FLAG_HALT    = 0;
   localparam int FLAG_STALL   = 1;
   localparam int FLAG_TIMEOUT = 2;
   localparam int FLAG_W       = 3;

   typedef struct packed {
      logic [TRACE_SEQ_W-1:0] seq;
      logic [TRACE_XLEN-1:0]  pc;
   } trace_entry_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pc_trace_unit_if.sv
// Valid/ready drain port of the trace buffer: the unit presents the head
// entry, the consumer (debug UART or bench) accepts it with trace_ready.
interface pc_trace_unit_if
   import trace_pkg::*;
#(
   parameter int XLEN  = TRACE_XLEN,
   parameter int SEQ_W = TRACE_SEQ_W
);

   logic             trace_valid;
   logic             trace_ready;
   logic [XLEN-1:0]  trace_pc;
   logic [SEQ_W-1:0] trace_seq;

   modport master (
      output trace_valid,
      output trace_pc,
      output trace_seq,
      input  trace_ready
   );

   modport slave (
      input  trace_valid,
      input  trace_pc,
      input  trace_seq,
      output trace_ready
   );

endinterface

// File: rtl/pc_trace_unit_fifo.sv
// Circular trace buffer: registered write, combinational head read.
// When full, a push either replaces the oldest entry or is discarded.
module trace_fifo #(
   parameter int DEPTH     = 16,
   parameter int W         = 48,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic                   clk,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop_ok;
   logic          do_write;
   logic          adv_rd;

   assign empty  = (count == '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign pop_ok = pop && !empty;
   assign level  = count;
   assign dout   = empty ? '0 : mem[rd_ptr];

   // A full-buffer overwrite advances the read pointer as if the oldest
   // entry had been popped, so occupancy stays at DEPTH.
   always_comb begin
      do_write = 1'b0;
      adv_rd   = pop_ok;
      if (push) begin
         if (!full || pop_ok) begin
            do_write = 1'b1;
         end else if (OVERWRITE) begin
            do_write = 1'b1;
            adv_rd   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (adv_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_write && !adv_rd) begin
            count <= count + 1'b1;
         end else if (!do_write && adv_rd) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/pc_trace_unit.sv
// PC trace and run-health monitor: captures one entry per entry into the
// fetch state and raises sticky halt / stall / timeout flags.
module pc_trace_unit
   import trace_pkg::*;
#(
   parameter int                 XLEN        = TRACE_XLEN,
   parameter int                 STATE_W     = 5,
   parameter logic [STATE_W-1:0] FETCH_STATE = FETCH_STATE_DEF,
   parameter int                 DEPTH       = 16,
   parameter int                 SEQ_W       = TRACE_SEQ_W,
   parameter bit                 OVERWRITE   = 1'b1,
   parameter int                 HALT_REPEAT = 4,
   parameter int                 STALL_LIMIT = 1024,
   parameter int unsigned        TIMEOUT     = 1000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic [STATE_W-1:0]     core_state,
   input  logic [XLEN-1:0]        pc_now,
   pc_trace_unit_if.master        trace,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            drop_cnt,
   output logic                   halt,
   output logic                   stall,
   output logic                   timeout
);

   localparam int RW = $clog2(HALT_REPEAT + 1);
   localparam int IW = $clog2(STALL_LIMIT + 1);
   localparam logic [31:0] CYC_TC  = 32'(TIMEOUT - 1);
   localparam logic [31:0] CYC_SAT = (TIMEOUT == 0) ? 32'hFFFF_FFFF : 32'(TIMEOUT);

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [XLEN-1:0]  pc;
   } entry_t;

   logic [STATE_W-1:0] prev_state;
   logic               capture;
   logic               pop;
   logic               wipe;
   logic               fifo_empty;
   logic               fifo_full;
   logic               drop_evt;
   logic [SEQ_W-1:0]   seq;
   entry_t             wr_entry;
   entry_t             head;
   logic [XLEN-1:0]    last_pc;
   logic [RW-1:0]      rep_cnt;
   logic [RW-1:0]      rep_next;
   logic [IW-1:0]      idle_cnt;
   logic [31:0]        cyc_cnt;
   logic [FLAG_W-1:0]  flags;

   assign wipe     = rst | clr;
   assign capture  = en && (core_state == FETCH_STATE) && (prev_state != FETCH_STATE);
   assign pop      = !fifo_empty && trace.trace_ready;
   assign drop_evt = capture && fifo_full && !pop;
   assign wr_entry = '{seq: seq, pc: pc_now};

   trace_fifo #(
      .DEPTH     (DEPTH),
      .W         ($bits(entry_t)),
      .OVERWRITE (OVERWRITE)
   ) u_fifo (
      .clk   (clk),
      .clear (wipe),
      .push  (capture),
      .pop   (pop),
      .din   (wr_entry),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (level)
   );

   assign trace.trace_valid = !fifo_empty;
   assign trace.trace_pc    = head.pc;
   assign trace.trace_seq   = head.seq;

   assign halt    = flags[FLAG_HALT];
   assign stall   = flags[FLAG_STALL];
   assign timeout = flags[FLAG_TIMEOUT];

   // rep_cnt == 0 means no PC captured yet, so the first capture never matches.
   always_comb begin
      rep_next = rep_cnt;
      if (capture) begin
         if ((rep_cnt != '0) && (pc_now == last_pc)) begin
            rep_next = (rep_cnt == RW'(HALT_REPEAT)) ? rep_cnt : rep_cnt + 1'b1;
         end else begin
            rep_next = RW'(1);
         end
      end
   end

   // seq survives clr so a consumer can still see the discontinuity.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_state <= '0;
         seq        <= '0;
      end else if (clr) begin
         prev_state <= '0;
      end else begin
         prev_state <= core_state;
         if (capture) begin
            seq <= seq + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wipe) begin
         drop_cnt <= '0;
         last_pc  <= '0;
         rep_cnt  <= '0;
         idle_cnt <= '0;
         flags    <= '0;
      end else begin
         if (drop_evt) begin
            drop_cnt <= sat_inc16(drop_cnt);
         end
         if (capture) begin
            last_pc <= pc_now;
         end
         rep_cnt <= rep_next;
         if (capture && (rep_next == RW'(HALT_REPEAT))) begin
            flags[FLAG_HALT] <= 1'b1;
         end
         if (capture) begin
            idle_cnt <= '0;
         end else if (en && (idle_cnt != IW'(STALL_LIMIT))) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IW'(STALL_LIMIT - 1)) begin
               flags[FLAG_STALL] <= 1'b1;
            end
         end
         if ((TIMEOUT != 0) && (cyc_cnt == CYC_TC)) begin
            flags[FLAG_TIMEOUT] <= 1'b1;
         end
      end
   end

   // Counter runs one step past the terminal count and parks there, so the
   // timeout flag cannot re-arm after a clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else if (cyc_cnt != CYC_SAT) begin
         cyc_cnt <= cyc_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pc_trace_unit.sv
// Directed bench for pc_trace_unit: table-driven capture/drain vectors plus
// hand sequences for overflow, halt, stall/timeout and mid-stream reset.
module tb_pc_trace_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        clr;
   logic [4:0]  cs;
   logic [31:0] pc;
   logic        rdy_a;
   logic        rdy_b;

   logic [2:0]  lvl_a, lvl_b;
   logic [15:0] drop_a, drop_b;
   logic        halt_a, halt_b, stall_a, stall_b, to_a, to_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_trace_unit_if #(.XLEN(32), .SEQ_W(16)) if_a ();
   pc_trace_unit_if #(.XLEN(32), .SEQ_W(16)) if_b ();

   assign if_a.trace_ready = rdy_a;
   assign if_b.trace_ready = rdy_b;

   pc_trace_unit #(
      .DEPTH(4), .OVERWRITE(1'b1), .HALT_REPEAT(4), .STALL_LIMIT(8), .TIMEOUT(20)
   ) u_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .core_state(cs), .pc_now(pc),
      .trace(if_a), .level(lvl_a), .drop_cnt(drop_a),
      .halt(halt_a), .stall(stall_a), .timeout(to_a)
   );

   pc_trace_unit #(
      .DEPTH(4), .OVERWRITE(1'b0), .HALT_REPEAT(4), .STALL_LIMIT(8), .TIMEOUT(20)
   ) u_b (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .core_state(cs), .pc_now(pc),
      .trace(if_b), .level(lvl_b), .drop_cnt(drop_b),
      .halt(halt_b), .stall(stall_b), .timeout(to_b)
   );

   typedef struct {
      logic        en;
      logic [4:0]  cs;
      logic [31:0] pc;
      logic        rdy;
      logic [2:0]  lvl;
      logic        vld;
      logic [31:0] hpc;
      logic [15:0] hseq;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(input logic e, input logic [4:0] s, input logic [31:0] p,
                               input logic r, input logic [2:0] l, input logic v,
                               input logic [31:0] hp, input logic [15:0] hs);
      vec_t t;
      t.en = e; t.cs = s; t.pc = p; t.rdy = r;
      t.lvl = l; t.vld = v; t.hpc = hp; t.hseq = hs;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; en = 1'b1; cs = 5'b00010; pc = '0;
      rdy_a = 1'b0; rdy_b = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic cap(input logic [31:0] p);
      cs = 5'b00001; pc = p;
      step();
   endtask

   task automatic idle();
      cs = 5'b00010;
      step();
   endtask

   initial begin
      logic [31:0] exp_pc  [4];
      logic [15:0] exp_seq [4];

      tbl[0]  = mk(1, 5'd1, 32'h0, 0, 3'd1, 1, 32'h0, 16'd0);
      tbl[1]  = mk(1, 5'd1, 32'h0, 0, 3'd1, 1, 32'h0, 16'd0);
      tbl[2]  = mk(1, 5'd1, 32'h0, 0, 3'd1, 1, 32'h0, 16'd0);
      tbl[3]  = mk(1, 5'd2, 32'h0, 0, 3'd1, 1, 32'h0, 16'd0);
      tbl[4]  = mk(1, 5'd1, 32'h4, 0, 3'd2, 1, 32'h0, 16'd0);
      tbl[5]  = mk(1, 5'd1, 32'h4, 0, 3'd2, 1, 32'h0, 16'd0);
      tbl[6]  = mk(1, 5'd1, 32'h4, 0, 3'd2, 1, 32'h0, 16'd0);
      tbl[7]  = mk(1, 5'd2, 32'h4, 0, 3'd2, 1, 32'h0, 16'd0);
      tbl[8]  = mk(1, 5'd1, 32'h8, 0, 3'd3, 1, 32'h0, 16'd0);
      tbl[9]  = mk(1, 5'd1, 32'h8, 0, 3'd3, 1, 32'h0, 16'd0);
      tbl[10] = mk(1, 5'd1, 32'h8, 0, 3'd3, 1, 32'h0, 16'd0);
      tbl[11] = mk(1, 5'd2, 32'h8, 1, 3'd2, 1, 32'h4, 16'd1);
      tbl[12] = mk(1, 5'd2, 32'h8, 1, 3'd1, 1, 32'h8, 16'd2);
      tbl[13] = mk(1, 5'd2, 32'h8, 1, 3'd0, 0, 32'h0, 16'd0);
      tbl[14] = mk(1, 5'd2, 32'h8, 1, 3'd0, 0, 32'h0, 16'd0);
      tbl[15] = mk(0, 5'd1, 32'hC, 0, 3'd0, 0, 32'h0, 16'd0);
      tbl[16] = mk(1, 5'd2, 32'hC, 0, 3'd0, 0, 32'h0, 16'd0);
      tbl[17] = mk(1, 5'd1, 32'hC, 0, 3'd1, 1, 32'hC, 16'd3);
      tbl[18] = mk(1, 5'd1, 32'hC, 1, 3'd0, 0, 32'h0, 16'd0);

      // reset state, sampled while rst is still held
      rst = 1'b1; clr = 1'b0; en = 1'b1; cs = 5'b00010; pc = '0;
      rdy_a = 1'b0; rdy_b = 1'b0;
      step();
      step();
      chk("rst_valid", if_a.trace_valid, 0);
      chk("rst_pc", if_a.trace_pc, 0);
      chk("rst_seq", if_a.trace_seq, 0);
      chk("rst_level", lvl_a, 0);
      chk("rst_drop", drop_a, 0);
      chk("rst_flags", {halt_a, stall_a, to_a}, 0);
      chk("rst_flags_b", {halt_b, stall_b, to_b, lvl_b}, 0);
      rst = 1'b0;

      // capture on fetch entry only, drain in order
      foreach (tbl[i]) begin
         en = tbl[i].en; cs = tbl[i].cs; pc = tbl[i].pc;
         rdy_a = tbl[i].rdy; rdy_b = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d_level", i), lvl_a, tbl[i].lvl);
         chk($sformatf("vec%0d_valid", i), if_a.trace_valid, tbl[i].vld);
         chk($sformatf("vec%0d_pc", i), if_a.trace_pc, tbl[i].hpc);
         chk($sformatf("vec%0d_seq", i), if_a.trace_seq, tbl[i].hseq);
         chk($sformatf("vec%0d_level_b", i), lvl_b, tbl[i].lvl);
      end
      rdy_a = 1'b0; rdy_b = 1'b0;

      // overflow: 6 captures into DEPTH=4 without draining
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cap(32'(i * 4));
         idle();
      end
      chk("ovw_level", lvl_a, 4);
      chk("ovw_drop", drop_a, 2);
      chk("ovw_head_seq", if_a.trace_seq, 2);
      chk("ovw_head_pc", if_a.trace_pc, 32'h08);
      chk("keep_level", lvl_b, 4);
      chk("keep_drop", drop_b, 2);
      chk("keep_head_seq", if_b.trace_seq, 0);
      chk("keep_head_pc", if_b.trace_pc, 32'h00);

      // capture with simultaneous pop on the full OVERWRITE=0 buffer
      rdy_b = 1'b1;
      cap(32'h18);
      rdy_b = 1'b0;
      chk("keep_sim_level", lvl_b, 4);
      chk("keep_sim_drop", drop_b, 2);
      chk("keep_sim_head_seq", if_b.trace_seq, 1);
      chk("ovw_third_drop", drop_a, 3);
      chk("ovw_third_head_seq", if_a.trace_seq, 3);
      chk("ovw_third_level", lvl_a, 4);
      idle();

      exp_seq[0] = 16'd1; exp_pc[0] = 32'h04;
      exp_seq[1] = 16'd2; exp_pc[1] = 32'h08;
      exp_seq[2] = 16'd3; exp_pc[2] = 32'h0C;
      exp_seq[3] = 16'd6; exp_pc[3] = 32'h18;
      rdy_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("keep_drain%0d_seq", i), if_b.trace_seq, exp_seq[i]);
         chk($sformatf("keep_drain%0d_pc", i), if_b.trace_pc, exp_pc[i]);
         idle();
      end
      rdy_b = 1'b0;
      chk("keep_drained_level", lvl_b, 0);
      chk("keep_drained_valid", if_b.trace_valid, 0);

      // halt on the 4th identical capture
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cap(32'h8000_0010);
         chk($sformatf("halt_cap%0d", i), halt_a, (i == 3) ? 1 : 0);
         idle();
      end
      clr = 1'b1;
      idle();
      clr = 1'b0;
      chk("clr_halt", halt_a, 0);
      chk("clr_level", lvl_a, 0);
      chk("clr_keeps_seq", 1'b1, 1'b1 & (if_a.trace_valid == 1'b0));
      cap(32'h10); idle();
      chk("post_clr_seq", if_a.trace_seq, 4);
      cap(32'h14); idle();
      cap(32'h10); idle();
      cap(32'h10); idle();
      cap(32'h10); idle();
      chk("no_halt_broken_run", halt_a, 0);
      chk("no_halt_broken_run_b", halt_b, 0);

      // stall at idle cycle 8, timeout at cycle 20
      do_reset();
      cs = 5'b00010;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("stall_k%0d", k), stall_a, (k >= 8) ? 1 : 0);
         chk($sformatf("timeout_k%0d", k), to_a, (k >= 20) ? 1 : 0);
      end
      chk("stall_b", stall_b, 1);
      chk("timeout_b", to_b, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_stall", stall_a, 0);
      chk("clr_timeout", to_a, 0);
      for (int j = 1; j <= 8; j++) begin
         step();
         chk($sformatf("restall_j%0d", j), stall_a, (j >= 8) ? 1 : 0);
      end
      chk("timeout_stays_clear", to_a, 0);

      // idle counter holds while capture is disabled
      clr = 1'b1;
      step();
      clr = 1'b0;
      en = 1'b0;
      for (int j = 0; j < 10; j++) step();
      chk("stall_hold_en0", stall_a, 0);
      en = 1'b1;
      for (int j = 0; j < 7; j++) step();
      chk("stall_en1_7", stall_a, 0);
      step();
      chk("stall_en1_8", stall_a, 1);

      // reset in the same cycle as a capture
      do_reset();
      cap(32'h100); idle();
      cap(32'h104); idle();
      cap(32'h108); idle();
      chk("mid_level3", lvl_a, 3);
      cs = 5'b00001; pc = 32'h40; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_level", lvl_a, 0);
      chk("mid_rst_valid", if_a.trace_valid, 0);
      chk("mid_rst_flags", {halt_a, stall_a, to_a}, 0);
      chk("mid_rst_drop", drop_a, 0);
      idle();
      cap(32'h44);
      chk("mid_next_seq", if_a.trace_seq, 0);
      chk("mid_next_pc", if_a.trace_pc, 32'h44);
      chk("mid_next_level", lvl_a, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
